// File: rtl/mult_pkg.sv
// Shared types and width helpers for the parametrised sequential multiplier controller.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        CALC      = 3'b001,
        CALC_DONE = 3'b100,
        ERR       = 3'b101
    } state_t;

    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

    function automatic int sel_width(input int s);
        return clog2_min1(s);
    endfunction

    // Shift select must reach 2*(S-1), the sum of the two largest segment indices.
    function automatic int shift_width(input int s);
        return clog2_min1(2 * s - 1);
    endfunction

    function automatic int cnt_width(input int s);
        return clog2_min1(s * s);
    endfunction

    function automatic bit widths_legal(input int width, input int nib);
        return (nib > 0) && (width % nib == 0) && (width / nib >= 2);
    endfunction

endpackage

// File: rtl/mult_step_cnt.sv
// Nested segment counter: j is the inner loop, i advances when j wraps.
module mult_step_cnt #(
    parameter int S  = 4,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          reset_a,
    input  logic          clr,
    input  logic          en,
    output logic [SW-1:0] i,
    output logic [SW-1:0] j,
    output logic          last
);

    localparam logic [SW-1:0] SMAX = SW'(S - 1);

    logic [SW-1:0] i_q, i_d;
    logic [SW-1:0] j_q, j_d;

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    // Both counters wrap together after the final step, so no separate clear is needed there.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
        end else if (en) begin
            if (j_q == SMAX) begin
                j_d = '0;
                i_d = (i_q == SMAX) ? '0 : i_q + 1'b1;
            end else begin
                j_d = j_q + 1'b1;
            end
        end
    end

    assign i    = i_q;
    assign j    = j_q;
    assign last = (i_q == SMAX) && (j_q == SMAX);

endmodule

// File: rtl/mult_control_param.sv
// Controller sequencing a WIDTH x WIDTH product through one NIB x NIB multiplier.
module mult_control_param
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NIB   = 4,
    localparam int S    = WIDTH / NIB,
    localparam int SW   = sel_width(S),
    localparam int SHW  = shift_width(S),
    localparam int CW   = cnt_width(S)
) (
    input  logic           clk,
    input  logic           reset_a,
    input  logic           start,
    input  logic           abort,
    output logic [SW-1:0]  a_sel,
    output logic [SW-1:0]  b_sel,
    output logic [SHW-1:0] shift_sel,
    output logic [CW-1:0]  step_cnt,
    output logic [2:0]     state_out,
    output logic           clk_ena,
    output logic           sclr_n,
    output logic           done,
    output logic           busy,
    output logic           err
);

    if (!widths_legal(WIDTH, NIB)) begin : g_bad_width
        $error("mult_control_param: WIDTH must be a multiple of NIB with WIDTH/NIB >= 2");
    end

    state_t        state_q, state_d;
    logic          cnt_clr, cnt_en, last;
    logic [SW-1:0] i, j;

    mult_step_cnt #(
        .S  (S),
        .SW (SW)
    ) u_step_cnt (
        .clk     (clk),
        .reset_a (reset_a),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .i       (i),
        .j       (j),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_ena   = 1'b0;
        sclr_n    = 1'b1;
        done      = 1'b0;
        a_sel     = '0;
        b_sel     = '0;
        shift_sel = '0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clk_ena = 1'b1;
                    sclr_n  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                // abort beats start; a stray start mid-product is a protocol error.
                if (abort) begin
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end else if (start) begin
                    state_d = ERR;
                end else begin
                    clk_ena   = 1'b1;
                    a_sel     = i;
                    b_sel     = j;
                    shift_sel = SHW'(i) + SHW'(j);
                    cnt_en    = 1'b1;
                    if (last) begin
                        state_d = CALC_DONE;
                    end
                end
            end
            CALC_DONE: begin
                done = 1'b1;
                if (start) begin
                    clk_ena = 1'b1;
                    sclr_n  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (start) begin
                    clk_ena = 1'b1;
                    sclr_n  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = CALC;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign step_cnt  = CW'(i) * CW'(S) + CW'(j);
    assign state_out = state_q;
    assign busy      = (state_q == CALC);
    assign err       = (state_q == ERR);

endmodule

// File: doc/mult_control_param.md
# mult_control_param

Parametrised controller for the sequential multiplier: sequences a WIDTH×WIDTH product through one NIB×NIB partial-product multiplier, an operand select mux, a shifter and an accumulator. It is the generalised successor of the fixed 8×8 controller.
- Step counting is internal; the datapath no longer supplies the count.
- New behaviours over the fixed controller: abort, busy/err status, and back-to-back start from the done state.

## Interface
- WIDTH, 16: operand width; must be a multiple of NIB.
- NIB, 4: partial-product multiplier width. S = WIDTH/NIB, and S ≥ 2.
- SW, derived: max(1, clog2(S)). Width of each segment select.
- SHW, derived: max(1, clog2(2S−1)). Width of the shift select.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_a  in  1  asynchronous, active-low reset.
- start  in  1  begin a new product; also the recovery input from ERR.
- abort  in  1  abandon the current product.
- a_sel  out  SW  segment of operand A fed to the multiplier.
- b_sel  out  SW  segment of operand B fed to the multiplier.
- shift_sel  out  SHW  partial-product shift, in units of NIB (= a_sel + b_sel).
- step_cnt  out  clog2(S·S)  index of the current partial product.
- state_out  out  3  current state encoding.
- clk_ena  out  1  accumulator/output register enable.
- sclr_n  out  1  synchronous clear of the accumulator, active-low.
- done  out  1  product valid.
- busy  out  1  high in CALC.
- err  out  1  high in ERR.

## Operation
- States and encodings: IDLE=000, CALC=001, CALC_DONE=100, ERR=101. Other codes return to IDLE on the next edge.
- Internal counters i (A segment) and j (B segment). j is the inner loop: j increments each CALC step; on wrap j→0 and i increments. Step order is (0,0),(0,1)…(S−1,S−1). step_cnt = i·S + j.
- Outputs are Mealy (combinational from state, counters, start, abort).
  - Defaults: clk_ena=0, sclr_n=1, done=0; a_sel, b_sel, shift_sel = 0 (never X).
- IDLE:
  - start=1: clk_ena=1, sclr_n=0, counters←0, next CALC.
  - Otherwise stay.
- CALC:
  - abort=1 takes priority: clk_ena=0, counters←0, next IDLE.
  - Else start=1: clk_ena=0, next ERR.
  - Else: clk_ena=1, a_sel=i, b_sel=j, shift_sel=i+j, and advance the counters. At step (S−1,S−1), next CALC_DONE and counters←0.
- CALC_DONE: done=1.
  - start=1: also clk_ena=1, sclr_n=0, next CALC (back-to-back product).
  - Otherwise next IDLE.
  - abort is ignored.
- ERR: err=1.
  - start=1: clk_ena=1, sclr_n=0, counters←0, next CALC.
  - Otherwise stay.
  - abort=1 without start: next IDLE.
- busy=1 exactly in CALC.

## Timing
- Reset: async assert forces state IDLE and i=j=0 immediately. Outputs then read as follows.
  - 0: done, clk_ena, busy, err, a_sel, b_sel, shift_sel, step_cnt, state_out.
  - 1: sclr_n.
- Reset release is synchronous to clk in effect; the first transition occurs on the first edge after deassertion.
- Latency, with start sampled high in cycle 0 (IDLE):
  - CALC occupies cycles 1…S².
  - done is high in cycle S²+1 for exactly one cycle.
  - WIDTH=8, NIB=4 gives 4 steps and done in cycle 5.
- Back-to-back: start high in the CALC_DONE cycle starts the next product's CALC in the following cycle, with no IDLE cycle in between.
- Reset mid-CALC: the product is discarded and the accumulator is not cleared by this block. The next start performs the clear.

## Structure
- Shared package mult_pkg:
  - state localparams (IDLE, CALC, CALC_DONE, ERR);
  - width helper function(s) for SW/SHW;
  - a WIDTH%NIB legality check (elaboration-time $error).
- One sub-module, mult_step_cnt: the nested i/j counter with clear, enable and last-step flag. Parameter S; outputs i, j, last.
- The FSM and output decode stay in mult_control_param.

## Test plan
- WIDTH=8, NIB=4; reset, pulse start for one cycle.
  - Steps 1–4 show (a_sel, b_sel, shift_sel) = (0,0,0), (0,1,1), (1,0,1), (1,1,2) with clk_ena=1.
  - done=1 in cycle 5, then IDLE.
- WIDTH=16, NIB=4: 16 CALC steps. shift_sel runs 0…6; the last step is (3,3,6); done in cycle 17; busy high for exactly 16 cycles.
- start raised during CALC step 2: ERR next cycle with err=1 and clk_ena=0. start again: sclr_n=0, CALC restarts at (0,0).
- start held high through the CALC_DONE cycle: done=1 and sclr_n=0 in the same cycle, next cycle CALC step (0,0), no IDLE visited.
- abort in CALC step 3: IDLE next cycle, counters 0. reset_a pulsed low mid-CALC: state_out=000 with no clock edge, all outputs at reset values.
